// File: rtl/execute_out_pipe_buffer.sv
// Elastic FWFT buffer for the LC3 execute-stage output bundle, valid/ready on the read side.
// Push-to-output latency 1 cycle; full pushes without a same-cycle pop are dropped and counted.
module execute_out_pipe_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int DEPTH          = 4,
  parameter int AF_LEVEL       = DEPTH - 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable_execute,
  input  logic [1:0]                    W_Control_in,
  input  logic                          Mem_Control_in,
  input  logic [REG_ADDR_WIDTH-1:0]     sr1_in,
  input  logic [REG_ADDR_WIDTH-1:0]     sr2_in,
  input  logic [REG_ADDR_WIDTH-1:0]     dr_in,
  input  logic [2:0]                    NZP_in,
  input  logic [DATA_WIDTH-1:0]         aluout_in,
  input  logic [DATA_WIDTH-1:0]         pcout_in,
  input  logic [DATA_WIDTH-1:0]         M_Data_in,
  input  logic [DATA_WIDTH-1:0]         IR_Exec_in,
  input  logic                          flush,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [1:0]                    W_Control_out,
  output logic                          Mem_Control_out,
  output logic [REG_ADDR_WIDTH-1:0]     sr1_out,
  output logic [REG_ADDR_WIDTH-1:0]     sr2_out,
  output logic [REG_ADDR_WIDTH-1:0]     dr_out,
  output logic [2:0]                    NZP_out,
  output logic [DATA_WIDTH-1:0]         aluout_out,
  output logic [DATA_WIDTH-1:0]         pcout_out,
  output logic [DATA_WIDTH-1:0]         M_Data_out,
  output logic [DATA_WIDTH-1:0]         IR_Exec_out,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  typedef struct packed {
    logic [1:0]                w_control;
    logic                      mem_control;
    logic [REG_ADDR_WIDTH-1:0] sr1;
    logic [REG_ADDR_WIDTH-1:0] sr2;
    logic [REG_ADDR_WIDTH-1:0] dr;
    logic [2:0]                nzp;
    logic [DATA_WIDTH-1:0]     aluout;
    logic [DATA_WIDTH-1:0]     pcout;
    logic [DATA_WIDTH-1:0]     m_data;
    logic [DATA_WIDTH-1:0]     ir_exec;
  } bundle_t;

  bundle_t         mem [DEPTH];
  bundle_t         wr_bundle;
  bundle_t         head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            pop;
  logic            push;
  logic            drop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign out_valid   = ~empty;

  assign pop  = out_valid & out_ready;
  assign push = enable_execute & (~full | pop);
  // Flush swallows the strobe entirely, so it can never register as a drop.
  assign drop = enable_execute & full & ~pop & ~flush;

  assign wr_bundle = '{w_control: W_Control_in, mem_control: Mem_Control_in,
                       sr1: sr1_in, sr2: sr2_in, dr: dr_in, nzp: NZP_in,
                       aluout: aluout_in, pcout: pcout_in, m_data: M_Data_in,
                       ir_exec: IR_Exec_in};

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wr_bundle;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

  // Zero the head when empty so the stale storage never leaks downstream.
  assign head = out_valid ? mem[rd_ptr] : '0;

  assign W_Control_out   = head.w_control;
  assign Mem_Control_out = head.mem_control;
  assign sr1_out         = head.sr1;
  assign sr2_out         = head.sr2;
  assign dr_out          = head.dr;
  assign NZP_out         = head.nzp;
  assign aluout_out      = head.aluout;
  assign pcout_out       = head.pcout;
  assign M_Data_out      = head.m_data;
  assign IR_Exec_out     = head.ir_exec;

endmodule

// File: tb/tb_execute_out_pipe_buffer.sv
// Bench for execute_out_pipe_buffer: directed scenarios plus random traffic against a queue model.
module tb_execute_out_pipe_buffer;
  localparam int DW = 16;
  localparam int RAW = 3;
  localparam int DEPTH = 4;
  localparam int BW = 2 + 1 + 3 * RAW + 3 + 4 * DW;

  logic clock = 1'b0;
  logic reset;
  logic enable_execute, flush, out_ready;
  logic [1:0] W_Control_in;
  logic Mem_Control_in;
  logic [RAW-1:0] sr1_in, sr2_in, dr_in;
  logic [2:0] NZP_in;
  logic [DW-1:0] aluout_in, pcout_in, M_Data_in, IR_Exec_in;
  logic out_valid;
  logic [1:0] W_Control_out;
  logic Mem_Control_out;
  logic [RAW-1:0] sr1_out, sr2_out, dr_out;
  logic [2:0] NZP_out;
  logic [DW-1:0] aluout_out, pcout_out, M_Data_out, IR_Exec_out;
  logic [2:0] count;
  logic full, almost_full, empty, overflow;
  logic [7:0] drop_count;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] q[$];
  logic m_ovf;
  int   m_drop;

  execute_out_pipe_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-1)) dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
    .sr1_in(sr1_in), .sr2_in(sr2_in), .dr_in(dr_in), .NZP_in(NZP_in),
    .aluout_in(aluout_in), .pcout_in(pcout_in), .M_Data_in(M_Data_in), .IR_Exec_in(IR_Exec_in),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
    .sr1_out(sr1_out), .sr2_out(sr2_out), .dr_out(dr_out), .NZP_out(NZP_out),
    .aluout_out(aluout_out), .pcout_out(pcout_out), .M_Data_out(M_Data_out), .IR_Exec_out(IR_Exec_out),
    .count(count), .full(full), .almost_full(almost_full), .empty(empty),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  function automatic logic [BW-1:0] cur_in();
    return {W_Control_in, Mem_Control_in, sr1_in, sr2_in, dr_in, NZP_in,
            aluout_in, pcout_in, M_Data_in, IR_Exec_in};
  endfunction

  function automatic logic [BW-1:0] got_bundle();
    return {W_Control_out, Mem_Control_out, sr1_out, sr2_out, dr_out, NZP_out,
            aluout_out, pcout_out, M_Data_out, IR_Exec_out};
  endfunction

  function automatic logic [BW-1:0] exp_bundle();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  task automatic set_bundle(input logic [DW-1:0] ir);
    W_Control_in   = 2'($urandom);
    Mem_Control_in = 1'($urandom);
    sr1_in = RAW'($urandom); sr2_in = RAW'($urandom); dr_in = RAW'($urandom);
    NZP_in = 3'($urandom);
    aluout_in = DW'($urandom); pcout_in = DW'($urandom); M_Data_in = DW'($urandom);
    IR_Exec_in = ir;
  endtask

  // One clock: drive the request, advance the queue model by the same rules, settle 1 time unit past the edge.
  task automatic step(input logic en, input logic rdy, input logic fl);
    logic pop_m, full_m;
    logic [BW-1:0] b;
    enable_execute = en; out_ready = rdy; flush = fl;
    pop_m  = (q.size() != 0) && rdy;
    full_m = (q.size() == DEPTH);
    b = cur_in();
    @(posedge clock);
    if (fl) q.delete();
    else begin
      if (pop_m) void'(q.pop_front());
      if (en && (!full_m || pop_m)) q.push_back(b);
      else if (en) begin
        m_ovf = 1'b1;
        if (m_drop != 255) m_drop++;
      end
    end
    #1;
    enable_execute = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic model_reset();
    q.delete(); m_ovf = 1'b0; m_drop = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
        almost_full !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b cnt=%0d e=%b f=%b af=%b ovf=%b dc=%0d, want 0 0 1 0 0 0 0",
               out_valid, count, empty, full, almost_full, overflow, drop_count);
    end
    checks++;
    if (got_bundle() !== '0) begin
      errors++; $display("FAIL reset_fields: got %h want 0", got_bundle());
    end
  endtask

  task automatic test_first_push();
    set_bundle(16'h0001); aluout_in = 16'h1234;
    // No bypass: before the edge the pushed bundle must not appear.
    enable_execute = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || aluout_out !== 16'h0) begin
      errors++; $display("FAIL no_bypass: got v=%b alu=%h want 0 0000", out_valid, aluout_out);
    end
    step(1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || aluout_out !== 16'h1234 || count !== 3'd1) begin
      errors++; $display("FAIL first_push: got v=%b alu=%h cnt=%0d want 1 1234 1", out_valid, aluout_out, count);
    end
    checks++;
    if (got_bundle() !== exp_bundle()) begin
      errors++; $display("FAIL first_push_bundle: got %h want %h", got_bundle(), exp_bundle());
    end
    step(0, 0, 1);
  endtask

  task automatic test_fill_drop();
    for (int i = 1; i <= 4; i++) begin
      set_bundle(DW'(16'h1000 + i));
      step(1, 0, 0);
      checks++;
      if (count !== 3'(i) || almost_full !== (i >= 3) || full !== (i == 4)) begin
        errors++;
        $display("FAIL fill_flags_%0d: got cnt=%0d af=%b f=%b want %0d %b %b", i, count, almost_full, full, i, i >= 3, i == 4);
      end
    end
    set_bundle(16'h1005);
    step(1, 0, 0);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1 || IR_Exec_out !== 16'h1001 || count !== 3'd4) begin
      errors++;
      $display("FAIL drop: got ovf=%b dc=%0d ir=%h cnt=%0d want 1 1 1001 4", overflow, drop_count, IR_Exec_out, count);
    end
  endtask

  task automatic test_full_push_pop();
    set_bundle(16'h1006);
    checks++;
    if (IR_Exec_out !== 16'h1001 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_head: got ir=%h v=%b want 1001 1", IR_Exec_out, out_valid);
    end
    step(1, 1, 0);
    checks++;
    if (count !== 3'd4 || drop_count !== 8'd1 || IR_Exec_out !== 16'h1002 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got cnt=%0d dc=%0d ir=%h f=%b want 4 1 1002 1", count, drop_count, IR_Exec_out, full);
    end
    checks++;
    if (got_bundle() !== exp_bundle()) begin
      errors++; $display("FAIL full_push_pop_bundle: got %h want %h", got_bundle(), exp_bundle());
    end
    step(0, 0, 1);
  endtask

  task automatic test_stream();
    int pushed = 0;
    int popped = 0;
    logic rdy;
    for (int cyc = 0; cyc < 100 && popped < 10; cyc++) begin
      rdy = (cyc % 2 == 0);
      set_bundle(DW'(pushed + 1));
      if (rdy && out_valid) begin
        checks++;
        if (IR_Exec_out !== DW'(popped + 1)) begin
          errors++; $display("FAIL stream_order_%0d: got %h want %h", popped, IR_Exec_out, DW'(popped + 1));
        end
        popped++;
      end
      if (pushed < 10 && q.size() < DEPTH) begin
        step(1, rdy, 0); pushed++;
      end else step(0, rdy, 0);
    end
    checks++;
    if (popped !== 10 || count !== 3'd0 || drop_count !== 8'd1) begin
      errors++; $display("FAIL stream_done: got popped=%0d cnt=%0d dc=%0d want 10 0 1", popped, count, drop_count);
    end
  endtask

  task automatic test_flush();
    logic ovf0;
    logic [7:0] dc0;
    for (int i = 0; i < 3; i++) begin set_bundle(DW'(16'h2000 + i)); step(1, 0, 0); end
    ovf0 = overflow; dc0 = drop_count;
    set_bundle(16'h2100);
    step(1, 1, 1);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0 || overflow !== ovf0 || drop_count !== dc0 ||
        got_bundle() !== '0) begin
      errors++;
      $display("FAIL flush: got cnt=%0d e=%b v=%b ovf=%b dc=%0d want 0 1 0 %b %0d",
               count, empty, out_valid, overflow, drop_count, ovf0, dc0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin set_bundle(DW'(16'h3000 + i)); step(1, 0, 0); end
    reset = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || got_bundle() !== '0 || count !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b fields=%h cnt=%0d ovf=%b dc=%0d want 0 0 0 0 0",
               out_valid, got_bundle(), count, overflow, drop_count);
    end
    #2 reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      set_bundle(DW'($urandom));
      step(1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
      checks++;
      if (got_bundle() !== exp_bundle() || out_valid !== (q.size() != 0) || count !== 3'(q.size()) ||
          full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || almost_full !== (q.size() >= DEPTH-1) ||
          overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
        errors++;
        if (bad < 5)
          $display("FAIL random_%0d: got fields=%h v=%b cnt=%0d ovf=%b dc=%0d want fields=%h cnt=%0d ovf=%b dc=%0d",
                   i, got_bundle(), out_valid, count, overflow, drop_count, exp_bundle(), q.size(), m_ovf, m_drop);
        bad++;
      end
    end
    checks++;
    if (m_drop == 0 || drop_count !== 8'(m_drop)) begin
      errors++; $display("FAIL random_drops: got dc=%0d want nonzero %0d", drop_count, m_drop);
    end
  endtask

  initial begin
    reset = 1'b1; enable_execute = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_bundle(16'h0);
    model_reset();
    #12 reset = 1'b0;
    test_reset();
    test_first_push();
    test_fill_drop();
    test_full_push_pop();
    test_stream();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
